// File: rtl/iob_bidir_port.sv
// Bidirectional pad port: write words onto a shared pad bus with turnaround
// guard cycles, and synchronise the externally driven bus back when listening.
module iob_bidir_port #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TURN_CYC    = 1
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              dir_o,
    inout  wire  [DATA_W-1:0] pad_io
);

    localparam int unsigned CNT_W  = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
    localparam int unsigned FILL_W = $clog2(SYNC_STAGES + 1);

    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(TURN_CYC - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SYNC_STAGES);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] TURN_TX = 2'd1;
    localparam logic [1:0] DRIVE   = 2'd2;
    localparam logic [1:0] TURN_RX = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] dout_q;
    logic [FILL_W-1:0] fill_q;
    logic [DATA_W-1:0] sync_q [SYNC_STAGES];
    logic              accept;

    // Status decoded purely from registers so pads release glitch-free on reset.
    assign dir_o      = (state_q == DRIVE);
    assign wr_ready_o = (state_q == IDLE) || (state_q == DRIVE);
    assign rd_valid_o = (state_q == IDLE) && (fill_q == FILL_MAX);
    assign rd_data_o  = sync_q[SYNC_STAGES-1];
    assign accept     = wr_valid_i & wr_ready_o;

    assign pad_io = dir_o ? dout_q : {DATA_W{1'bz}};

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = TURN_TX;
                    cnt_d   = CNT_LOAD;
                end
            end
            TURN_TX: begin
                if (cnt_q == '0) state_d = DRIVE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            DRIVE: begin
                if (!accept) begin
                    state_d = TURN_RX;
                    cnt_d   = CNT_LOAD;
                end
            end
            TURN_RX: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            dout_q <= '0;
        end else if (accept) begin
            dout_q <= wr_data_i;
        end
    end

    // Pad sampled in every state; validity is gated separately by the fill count.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= pad_io;
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            fill_q <= '0;
        end else if (state_q != IDLE) begin
            fill_q <= '0;
        end else if (fill_q != FILL_MAX) begin
            fill_q <= fill_q + FILL_W'(1);
        end
    end

endmodule

// File: tb/tb_iob_bidir_port.sv
// Bench for iob_bidir_port: directed scenarios plus a randomized run against
// a cycle-level behavioural model of the bus protocol.
module tb_iob_bidir_port;

    localparam logic [7:0] HIZ    = 8'hFF;
    localparam int         RAND_N = 400;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic [7:0] wr_data = '0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       dir;
    wire  [7:0] pad;
    logic       ext_en = 1'b0;
    logic [7:0] ext_val = '0;

    logic [7:0] wr_data3 = '0;
    logic       wr_valid3 = 1'b0;
    logic       wr_ready3;
    logic [7:0] rd_data3;
    logic       rd_valid3;
    logic       dir3;
    wire  [7:0] pad3;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    int         m_busy;
    bit         m_to_drive;
    bit         m_driving;
    logic [7:0] m_word;
    int         m_idle_run;

    always #5 clk = ~clk;

    pullup (pad);
    pullup (pad3);
    assign pad = ext_en ? ext_val : 8'bz;

    iob_bidir_port #(.DATA_W(8), .SYNC_STAGES(2), .TURN_CYC(1)) u_dut (
        .clk_i(clk), .arst_i(arst), .wr_data_i(wr_data), .wr_valid_i(wr_valid),
        .wr_ready_o(wr_ready), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
        .dir_o(dir), .pad_io(pad)
    );

    iob_bidir_port #(.DATA_W(8), .SYNC_STAGES(2), .TURN_CYC(3)) u_dut3 (
        .clk_i(clk), .arst_i(arst), .wr_data_i(wr_data3), .wr_valid_i(wr_valid3),
        .wr_ready_o(wr_ready3), .rd_data_o(rd_data3), .rd_valid_o(rd_valid3),
        .dir_o(dir3), .pad_io(pad3)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic model_reset();
        m_busy = 0; m_to_drive = 0; m_driving = 0; m_word = '0; m_idle_run = 0;
    endtask

    // One clock edge of the protocol: turnaround countdown, drive, or listen.
    task automatic model_edge(input bit acc, input logic [7:0] d);
        if (m_busy > 0) begin
            m_idle_run = 0;
            m_busy--;
            if (m_busy == 0 && m_to_drive) m_driving = 1;
        end else if (m_driving) begin
            m_idle_run = 0;
            if (acc) m_word = d;
            else begin m_driving = 0; m_busy = 1; m_to_drive = 0; end
        end else begin
            if (m_idle_run < 2) m_idle_run++;
            if (acc) begin m_word = d; m_busy = 1; m_to_drive = 1; end
        end
    endtask

    task automatic test_reset();
        arst = 1'b1; ext_en = 1'b0; wr_valid = 1'b0;
        #3;
        n_cmp++;
        if ({dir, wr_ready, rd_valid} !== 3'b010) begin
            n_bad++; $display("FAIL reset_flags: got %b want 010", {dir, wr_ready, rd_valid});
        end
        n_cmp++;
        if (rd_data !== 8'h00) begin
            n_bad++; $display("FAIL reset_rd_data: got %h want 00", rd_data);
        end
        n_cmp++;
        if (pad !== HIZ) begin
            n_bad++; $display("FAIL reset_pad: got %h want %h", pad, HIZ);
        end
        n_cmp++;
        if ({dir3, wr_ready3, rd_valid3, rd_data3} !== {3'b010, 8'h00}) begin
            n_bad++; $display("FAIL reset_dut3: got %b/%h", {dir3, wr_ready3, rd_valid3}, rd_data3);
        end
    endtask

    task automatic test_listen();
        ext_en = 1'b1; ext_val = 8'h3C;
        tick();
        arst = 1'b0;
        #1;
        n_cmp++;
        if ({dir, rd_valid} !== 2'b00) begin
            n_bad++; $display("FAIL listen_e0: dir/valid got %b want 00", {dir, rd_valid});
        end
        tick();
        n_cmp++;
        if ({dir, rd_valid} !== 2'b00) begin
            n_bad++; $display("FAIL listen_e1: dir/valid got %b want 00", {dir, rd_valid});
        end
        tick();
        n_cmp++;
        if ({dir, rd_valid, rd_data} !== {2'b01, 8'h3C}) begin
            n_bad++; $display("FAIL listen_e2: got dir=%b valid=%b data=%h want 0/1/3c", dir, rd_valid, rd_data);
        end
    endtask

    task automatic test_single_write();
        wr_valid = 1'b1; wr_data = 8'hA5;
        tick();
        wr_valid = 1'b0; ext_en = 1'b0;
        #1;
        n_cmp++;
        if ({dir, wr_ready, rd_valid, pad} !== {3'b000, HIZ}) begin
            n_bad++; $display("FAIL single_turn_tx: got %b pad=%h want 000 pad=%h", {dir, wr_ready, rd_valid}, pad, HIZ);
        end
        tick();
        n_cmp++;
        if ({dir, wr_ready, rd_valid, pad} !== {3'b110, 8'hA5}) begin
            n_bad++; $display("FAIL single_drive: got %b pad=%h want 110 pad=a5", {dir, wr_ready, rd_valid}, pad);
        end
        tick();
        n_cmp++;
        if ({dir, wr_ready, pad} !== {2'b00, HIZ}) begin
            n_bad++; $display("FAIL single_turn_rx: got %b pad=%h want 00 pad=%h", {dir, wr_ready}, pad, HIZ);
        end
        ext_en = 1'b1; ext_val = 8'h5A;
        tick();
        n_cmp++;
        if ({dir, wr_ready, rd_valid} !== 3'b010) begin
            n_bad++; $display("FAIL single_idle0: got %b want 010", {dir, wr_ready, rd_valid});
        end
        tick();
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_bad++; $display("FAIL single_idle1: valid got %b want 0", rd_valid);
        end
        tick();
        n_cmp++;
        if ({rd_valid, rd_data} !== {1'b1, 8'h5A}) begin
            n_bad++; $display("FAIL single_idle2: valid=%b data=%h want 1/5a", rd_valid, rd_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3];
        words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
        ext_en = 1'b0;
        wr_valid = 1'b1; wr_data = words[0];
        tick();
        wr_data = words[1];
        #1;
        n_cmp++;
        if ({dir, wr_ready, pad} !== {2'b00, HIZ}) begin
            n_bad++; $display("FAIL b2b_turn: got %b pad=%h want 00 pad=%h", {dir, wr_ready}, pad, HIZ);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            wr_data = (i < 2) ? words[i+1] : 8'h00;
            wr_valid = (i < 1);
            if (i == 1) wr_valid = 1'b1;
            #1;
            n_cmp++;
            if ({dir, pad} !== {1'b1, words[i]}) begin
                n_bad++; $display("FAIL b2b_word%0d: dir=%b pad=%h want 1/%h", i, dir, pad, words[i]);
            end
        end
        wr_valid = 1'b0;
        tick();
        n_cmp++;
        if ({dir, pad} !== {1'b0, HIZ}) begin
            n_bad++; $display("FAIL b2b_release: dir=%b pad=%h want 0/%h", dir, pad, HIZ);
        end
        tick();
    endtask

    task automatic test_turn_rx_write();
        wr_valid = 1'b1; wr_data = 8'h11;
        tick();
        wr_valid = 1'b0;
        tick();
        tick();
        wr_valid = 1'b1; wr_data = 8'h77;
        #1;
        n_cmp++;
        if ({dir, wr_ready} !== 2'b00) begin
            n_bad++; $display("FAIL rxw_ready: got %b want 00", {dir, wr_ready});
        end
        tick();
        n_cmp++;
        if ({wr_ready, u_dut.dout_q} !== {1'b1, 8'h11}) begin
            n_bad++; $display("FAIL rxw_nocapture: ready=%b dout=%h want 1/11", wr_ready, u_dut.dout_q);
        end
        tick();
        wr_valid = 1'b0;
        #1;
        n_cmp++;
        if ({dir, pad} !== {1'b0, HIZ}) begin
            n_bad++; $display("FAIL rxw_turn: dir=%b pad=%h want 0/%h", dir, pad, HIZ);
        end
        tick();
        n_cmp++;
        if ({dir, pad} !== {1'b1, 8'h77}) begin
            n_bad++; $display("FAIL rxw_drive: dir=%b pad=%h want 1/77", dir, pad);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_in_drive();
        wr_valid = 1'b1; wr_data = 8'h99;
        tick();
        wr_valid = 1'b0;
        tick();
        n_cmp++;
        if ({dir, pad} !== {1'b1, 8'h99}) begin
            n_bad++; $display("FAIL rid_drive: dir=%b pad=%h want 1/99", dir, pad);
        end
        #1;
        arst = 1'b1; wr_valid = 1'b1; wr_data = 8'hEE;
        #1;
        n_cmp++;
        if ({dir, wr_ready, rd_valid, pad, rd_data, u_dut.dout_q} !== {3'b010, HIZ, 8'h00, 8'h00}) begin
            n_bad++; $display("FAIL rid_release: flags=%b pad=%h rd=%h dout=%h", {dir, wr_ready, rd_valid}, pad, rd_data, u_dut.dout_q);
        end
        tick();
        n_cmp++;
        if ({dir, u_dut.dout_q} !== {1'b0, 8'h00}) begin
            n_bad++; $display("FAIL rid_reset_wins: dir=%b dout=%h want 0/00", dir, u_dut.dout_q);
        end
        wr_valid = 1'b0;
        arst = 1'b0;
        tick();
        n_cmp++;
        if ({dir, wr_ready, pad} !== {2'b01, HIZ}) begin
            n_bad++; $display("FAIL rid_idle: got %b pad=%h want 01/%h", {dir, wr_ready}, pad, HIZ);
        end
    endtask

    task automatic test_turn3();
        int n;
        wr_valid3 = 1'b1; wr_data3 = 8'hC3;
        tick();
        wr_valid3 = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (dir3 === 1'b1) break;
            if (pad3 === HIZ && wr_ready3 === 1'b0) n++;
            tick();
        end
        n_cmp++;
        if (n != 3) begin
            n_bad++; $display("FAIL t3_tx_cycles: got %0d want 3", n);
        end
        n_cmp++;
        if ({dir3, pad3} !== {1'b1, 8'hC3}) begin
            n_bad++; $display("FAIL t3_drive: dir=%b pad=%h want 1/c3", dir3, pad3);
        end
        tick();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (wr_ready3 === 1'b1) break;
            if (pad3 === HIZ && dir3 === 1'b0) n++;
            tick();
        end
        n_cmp++;
        if (n != 3 || {dir3, wr_ready3} !== 2'b01) begin
            n_bad++; $display("FAIL t3_rx_cycles: got %0d ready=%b want 3/1", n, wr_ready3);
        end
    endtask

    task automatic test_random();
        logic [7:0] hist [RAND_N];
        logic [7:0] pdata, exp_pad;
        bit         pend, listen, acc, exp_valid;
        arst = 1'b1; wr_valid = 1'b0; ext_en = 1'b1;
        tick();
        arst = 1'b0;
        model_reset();
        pend = 0; pdata = '0;
        for (int c = 0; c < RAND_N; c++) begin
            listen = (m_busy == 0) && !m_driving;
            ext_en = listen;
            ext_val = 8'($urandom);
            if (!pend && $urandom_range(0, 2) != 0) begin
                pend = 1; pdata = 8'($urandom);
            end
            wr_valid = pend;
            wr_data = pend ? pdata : 8'($urandom);
            #1;
            exp_valid = listen && (m_idle_run >= 2);
            exp_pad = m_driving ? m_word : (listen ? ext_val : HIZ);
            hist[c] = exp_pad;
            n_cmp++;
            if ({wr_ready, dir, rd_valid} !== {m_busy == 0, m_driving, exp_valid}) begin
                n_bad++; $display("FAIL rnd_flags c=%0d: got %b want %b", c, {wr_ready, dir, rd_valid}, {m_busy == 0, m_driving, exp_valid});
            end
            n_cmp++;
            if (pad !== exp_pad) begin
                n_bad++; $display("FAIL rnd_pad c=%0d: got %h want %h", c, pad, exp_pad);
            end
            if (exp_valid && c >= 2) begin
                n_cmp++;
                if (rd_data !== hist[c-2]) begin
                    n_bad++; $display("FAIL rnd_rd_data c=%0d: got %h want %h", c, rd_data, hist[c-2]);
                end
            end
            acc = pend && (m_busy == 0);
            @(posedge clk);
            model_edge(acc, pdata);
            if (acc) pend = 0;
            #2;
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_listen();
        test_single_write();
        test_back_to_back();
        test_turn_rx_write();
        test_reset_in_drive();
        test_turn3();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
